// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply uses one shift-add step per cycle (LSB first); divide uses one
// restoring shift-subtract step per cycle (MSB first). Signed ops work on
// magnitudes, and the sign is reapplied in the FIX cycle.
module mdu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        qneg_q, qneg_d;      // product sign (mult) or quotient sign (div)
  logic        rneg_q, rneg_d;      // remainder sign = dividend sign
  logic [31:0] acc_hi_q, acc_hi_d;  // partial product high / partial remainder
  logic [31:0] acc_lo_q, acc_lo_d;  // multiplier bits / dividend-quotient bits
  logic [31:0] opnd_q, opnd_d;      // multiplicand / divisor magnitude
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        signed_op;
  logic        op_valid;
  logic        accept;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] prod_mag;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Operand conditioning and one iteration step of each datapath.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    op_valid  = (op[2:1] != 2'b11);
    accept    = (state_q == S_IDLE) && start && !flush && op_valid;
    a_mag     = (signed_op && a[31]) ? (~a + 32'd1) : a;
    b_mag     = (signed_op && b[31]) ? (~b + 32'd1) : b;

    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);

    div_sh    = {acc_hi_q, acc_lo_q[31]};
    div_ge    = (div_sh >= {1'b0, opnd_q});
    // The true difference is below the divisor, so 32 bits hold it exactly.
    div_diff  = div_sh[31:0] - opnd_q;

    prod_mag  = {acc_hi_q, acc_lo_q};
    prod_fix  = qneg_q ? (~prod_mag + 64'd1) : prod_mag;
    quo_fix   = qneg_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
    rem_fix   = rneg_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_MTHI) begin
            hi_d   = a;
            done_d = 1'b1;
          end else if (op == OP_MTLO) begin
            lo_d   = a;
            done_d = 1'b1;
          end else if (op[1] && (b == '0)) begin
            hi_d   = a;
            lo_d   = '1;
            done_d = 1'b1;
            dbz_d  = 1'b1;
          end else begin
            state_d  = S_ITER;
            cnt_d    = '0;
            is_div_d = op[1];
            acc_hi_d = '0;
            acc_lo_d = a_mag;
            opnd_d   = b_mag;
            qneg_d   = signed_op && (a[31] ^ b[31]);
            rneg_d   = signed_op && a[31];
          end
        end
      end

      S_ITER: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_hi_d = div_ge ? div_diff : div_sh[31:0];
            acc_lo_d = {acc_lo_q[30:0], div_ge};
          end else begin
            acc_hi_d = mul_sum[32:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port start, input, 1 bit: EX-stage multiply/divide instruction valid.
REQ-004 The block SHALL have port op, input, 3 bits, encoded as follows:
- 000 mult
- 001 multu
- 010 div
- 011 divu
- 100 mthi
- 101 mtlo
- 110 and 111 reserved
REQ-005 The block SHALL have port a, input, 32 bits: rs operand.
REQ-006 The block SHALL have port b, input, 32 bits: rt operand.
REQ-007 The block SHALL have port flush, input, 1 bit: abort the in-flight operation.
REQ-008 The block SHALL have port busy, output, 1 bit: operation in progress; the pipeline stalls on it.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle result-written pulse.
REQ-010 The block SHALL have port dbz, output, 1 bit: one-cycle divide-by-zero pulse, coincident with done.
REQ-011 The block SHALL have ports hi and lo, outputs, 32 bits each: architectural HI/LO registers.

Function
REQ-012 The block SHALL implement states IDLE, ITER and FIX, plus a 5-bit iteration counter.
REQ-013 Accept: start=1 in IDLE with flush=0 and a non-reserved op SHALL capture op, a and b at that edge; a and b are don't-care afterwards.
REQ-014 start SHALL be ignored while busy=1.
REQ-015 start SHALL be ignored for reserved op values; no state change occurs.
REQ-016 mthi SHALL write hi<=a at the accept edge, assert done the following cycle, and never assert busy; mtlo SHALL do the same with lo<=a.
REQ-017 mult/multu/div/divu with a nonzero divisor SHALL take IDLE->ITER with counter=0, on the following schedule:
- busy=1 from the cycle after accept;
- ITER lasts exactly 32 cycles, counter 0..31;
- after counter=31, ITER->FIX;
- FIX lasts one cycle, then FIX->IDLE.
- busy SHALL therefore be high for exactly 33 cycles.
REQ-018 Datapath: the block SHALL operate on operand magnitudes for signed ops and raw values for unsigned ops.
- ITER performs one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, MSB first for divide.
REQ-019 FIX SHALL apply sign correction and write the result:
- multiply: {hi,lo} = 64-bit two's-complement product;
- divide: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
REQ-020 hi/lo SHALL update only at the FIX->IDLE edge; done SHALL be 1 in the cycle after that edge, with busy=0 in that cycle.
REQ-021 A new start SHALL be acceptable in the same cycle done=1.
REQ-022 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000 with no dbz.
REQ-023 div/divu with b=0 SHALL bypass ITER: at the accept edge hi<=a and lo<=0xFFFFFFFF; done=1 and dbz=1 the following cycle; busy never asserted.
REQ-024 flush=1 in ITER or FIX SHALL return the block to IDLE at the next edge, with:
- busy=0 next cycle;
- hi/lo unchanged;
- no done.
REQ-025 flush=1 with start=1 in IDLE: flush SHALL win and nothing is accepted.
REQ-026 done and dbz SHALL be registered outputs that are high for one cycle only.

Reset
REQ-027 reset=0 SHALL asynchronously force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0 and dbz=0, including mid-operation.
REQ-028 After reset deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-029 The bench SHALL cover mult a=0xFFFFFFFF, b=0x00000002 -> busy for 33 cycles, then done with hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-030 The bench SHALL cover multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE, 34 cycles from accept to done.
REQ-031 The bench SHALL cover div a=0xFFFFFFF9 (-7), b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; also div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 The bench SHALL cover divu a=5, b=0 -> next cycle done=1, dbz=1, hi=0x00000005, lo=0xFFFFFFFF, busy never high.
REQ-033 The bench SHALL cover mthi a=0x12345678 then back-to-back mult in the done cycle -> hi=0x12345678 visible, second op accepted with no gap.
REQ-034 The bench SHALL cover aborts: flush at ITER counter=9 -> busy=0 next cycle, hi/lo hold prior values, no done; separately, reset=0 mid-ITER -> all outputs zero immediately.
